// File: rtl/jpeg_pkg.sv
// Shared constants, types and helpers for the JPEG entropy-coded stream packer.
package jpeg_pkg;

  localparam int ACC_W     = 64;
  localparam int DC_CODE_W = 9;
  localparam int AC_CODE_W = 16;
  localparam int AMP_W     = 8;

  localparam logic [7:0] MARKER_BYTE = 8'hFF;
  localparam logic [7:0] STUFF_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DC_CODE = 3'd1,
    ST_DC_AMP  = 3'd2,
    ST_AC_CODE = 3'd3,
    ST_AC_AMP  = 3'd4
  } append_state_e;

  typedef struct packed {
    logic [DC_CODE_W-1:0] dc_code;
    logic [7:0]           dc_len;
    logic [AMP_W-1:0]     dc_amp;
    logic [7:0]           dc_size;
    logic [AC_CODE_W-1:0] ac_code;
    logic [7:0]           ac_len;
    logic [AMP_W-1:0]     ac_amp;
    logic [7:0]           ac_size;
    logic                 last;
  } capture_t;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Single-entry output stage: holds one byte for the consumer and follows every
// 0xFF it hands over with a stuffed 0x00.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       empty_next
);

  logic       xfer;
  logic       valid_d;
  logic [7:0] data_d;

  // Handshake: a byte moves when byte_valid && byte_ready; while byte_valid is
  // high and byte_ready low, byte_out holds and byte_valid stays high. A new
  // byte may be loaded in the same cycle a non-marker byte leaves.
  always_comb begin
    xfer     = byte_valid && byte_ready;
    in_ready = !byte_valid || (xfer && (byte_out != MARKER_BYTE));
    valid_d  = byte_valid;
    data_d   = byte_out;
    if (xfer && (byte_out == MARKER_BYTE)) begin
      valid_d = 1'b1;
      data_d  = STUFF_BYTE;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_byte;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    empty_next = !valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
    end else begin
      byte_valid <= valid_d;
      byte_out   <= data_d;
    end
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs DC/AC Huffman codes and amplitude bits MSB-first into a byte stream,
// with 0xFF/0x00 stuffing, 1-bit padding on flush and a sticky error flag.
module huffman_bit_packer
  import jpeg_pkg::*;
#(
  parameter int ACC_W = jpeg_pkg::ACC_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 jpeg_out_enable,
  input  logic                 jpeg_out_end,
  input  logic [8:0]           jpeg_dc_out,
  input  logic [7:0]           jpeg_dc_out_length,
  input  logic [7:0]           jpeg_dc_code_list,
  input  logic [7:0]           jpeg_dc_code_size,
  input  logic [15:0]          huffman_code,
  input  logic [7:0]           huffman_code_length,
  input  logic [7:0]           code_out,
  input  logic [7:0]           code_size_out,
  input  logic                 flush,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 packer_busy,
  output logic                 flush_done,
  output logic                 overflow,
  output append_state_e        fsm_state
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  append_state_e        state_q, state_d;
  capture_t             cap_q;
  logic                 first_in_block, flush_pend;
  logic [ACC_W-1:0]     acc_q, acc_d, add_mask, add_bits;
  logic [CNT_W-1:0]     acc_cnt, cnt_d;
  logic [AC_CODE_W-1:0] fld;
  logic [7:0]           raw_len, fld_w, add_len, pad_len, drain_byte;
  logic [31:0]          sum_w;
  logic                 cap_now, append_en, pad_en, clamp_err, acc_ovf, do_add;
  logic                 drain, st_in_ready, st_empty_next, done_now;

  always_comb begin
    cap_now   = jpeg_out_enable && (state_q == ST_IDLE) && !flush_pend;
    state_d   = state_q;
    fld       = '0;
    raw_len   = 8'd0;
    fld_w     = 8'd0;
    append_en = 1'b0;
    case (state_q)
      ST_IDLE: if (cap_now) state_d = first_in_block ? ST_DC_CODE : ST_AC_CODE;
      ST_DC_CODE: begin
        fld = AC_CODE_W'(cap_q.dc_code); raw_len = cap_q.dc_len;  fld_w = 8'(DC_CODE_W);
        append_en = 1'b1; state_d = ST_DC_AMP;
      end
      ST_DC_AMP: begin
        fld = AC_CODE_W'(cap_q.dc_amp);  raw_len = cap_q.dc_size; fld_w = 8'(AMP_W);
        append_en = 1'b1; state_d = ST_AC_CODE;
      end
      ST_AC_CODE: begin
        fld = cap_q.ac_code;             raw_len = cap_q.ac_len;  fld_w = 8'(AC_CODE_W);
        append_en = 1'b1; state_d = ST_AC_AMP;
      end
      ST_AC_AMP: begin
        fld = AC_CODE_W'(cap_q.ac_amp);  raw_len = cap_q.ac_size; fld_w = 8'(AMP_W);
        append_en = 1'b1; state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush padding reuses the append path with an all-ones field.
    clamp_err = append_en && (raw_len > fld_w);
    pad_en    = flush_pend && (state_q == ST_IDLE) && (acc_cnt[2:0] != 3'd0);
    pad_len   = 8'd8 - 8'(acc_cnt[2:0]);
    add_len   = append_en ? clamp_len(raw_len, fld_w) : (pad_en ? pad_len : 8'd0);
    add_mask  = ~({ACC_W{1'b1}} << add_len);
    add_bits  = append_en ? (ACC_W'(fld) & add_mask) : add_mask;
    sum_w     = 32'(acc_cnt) + 32'(add_len);
    acc_ovf   = sum_w > 32'(ACC_W);
    do_add    = (add_len != 8'd0) && !acc_ovf;

    // Drain reads the pre-append accumulator; the appended bits land below it.
    drain      = (acc_cnt >= CNT_W'(8)) && st_in_ready;
    drain_byte = 8'(acc_q >> (acc_cnt - CNT_W'(8)));
    acc_d      = do_add ? ((acc_q << add_len) | add_bits) : acc_q;
    cnt_d      = acc_cnt + (do_add ? CNT_W'(add_len) : '0) - (drain ? CNT_W'(8) : '0);

    done_now = (flush || flush_pend) && (state_q == ST_IDLE) && !cap_now &&
               (acc_cnt == '0) && st_empty_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cap_q          <= '0;
      first_in_block <= 1'b1;
      flush_pend     <= 1'b0;
      acc_q          <= '0;
      acc_cnt        <= '0;
      flush_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_now) begin
        cap_q <= '{dc_code: jpeg_dc_out,  dc_len: jpeg_dc_out_length,
                   dc_amp:  jpeg_dc_code_list, dc_size: jpeg_dc_code_size,
                   ac_code: huffman_code, ac_len: huffman_code_length,
                   ac_amp:  code_out,     ac_size: code_size_out,
                   last:    jpeg_out_end};
      end
      acc_q      <= acc_d;
      acc_cnt    <= cnt_d;
      flush_done <= done_now;
      if (done_now)    flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;
      if (done_now)                   first_in_block <= 1'b1;
      else if (state_q == ST_AC_AMP)  first_in_block <= cap_q.last;
      if ((jpeg_out_enable && !cap_now) || clamp_err || acc_ovf) overflow <= 1'b1;
    end
  end

  jpeg_byte_stuffer u_stuffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (acc_cnt >= CNT_W'(8)),
    .in_byte    (drain_byte),
    .in_ready   (st_in_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .empty_next (st_empty_next)
  );

  assign packer_busy = (state_q != ST_IDLE) || (acc_cnt != '0) || byte_valid;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer: a bit-queue reference model builds
// the expected byte stream; a monitor collects the bytes the DUT hands over.
module tb_huffman_bit_packer;
  import jpeg_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          jpeg_out_enable = 1'b0, jpeg_out_end = 1'b0;
  logic [8:0]    jpeg_dc_out = '0;
  logic [7:0]    jpeg_dc_out_length = '0, jpeg_dc_code_list = '0, jpeg_dc_code_size = '0;
  logic [15:0]   huffman_code = '0;
  logic [7:0]    huffman_code_length = '0, code_out = '0, code_size_out = '0;
  logic          flush = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b1;
  logic          packer_busy, flush_done, overflow;
  append_state_e fsm_state;

  typedef struct {
    logic [8:0]  dcc;
    logic [7:0]  dcl, dca, dcs;
    logic [15:0] acc;
    logic [7:0]  acl, aca, acs;
    logic        last;
  } pulse_t;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         bits_q[$];
  bit         first_blk = 1'b1;
  int         total = 0;
  int         bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  huffman_bit_packer dut (
    .clock (clock), .reset_n (reset_n),
    .jpeg_out_enable (jpeg_out_enable), .jpeg_out_end (jpeg_out_end),
    .jpeg_dc_out (jpeg_dc_out), .jpeg_dc_out_length (jpeg_dc_out_length),
    .jpeg_dc_code_list (jpeg_dc_code_list), .jpeg_dc_code_size (jpeg_dc_code_size),
    .huffman_code (huffman_code), .huffman_code_length (huffman_code_length),
    .code_out (code_out), .code_size_out (code_size_out),
    .flush (flush), .byte_out (byte_out), .byte_valid (byte_valid),
    .byte_ready (byte_ready), .packer_busy (packer_busy),
    .flush_done (flush_done), .overflow (overflow), .fsm_state (fsm_state)
  );

  always @(negedge clock)
    if (reset_n && byte_valid && byte_ready) got_q.push_back(byte_out);

  // ---------------- reference model ----------------
  function automatic void model_clear();
    exp_q.delete(); got_q.delete(); bits_q.delete(); first_blk = 1'b1;
  endfunction

  function automatic void model_pack();
    while (bits_q.size() >= 8) begin
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void model_push(input logic [15:0] v, input int len, input int max_len);
    int n;
    n = (len > max_len) ? max_len : len;
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endfunction

  function automatic void model_pulse(input pulse_t p);
    if (first_blk) begin
      model_push(16'(p.dcc), int'(p.dcl), 9);
      model_push(16'(p.dca), int'(p.dcs), 8);
    end
    model_push(p.acc, int'(p.acl), 16);
    model_push(16'(p.aca), int'(p.acs), 8);
    first_blk = p.last;
    model_pack();
  endfunction

  function automatic void model_flush();
    while (bits_q.size() % 8 != 0) bits_q.push_back(1'b1);
    model_pack();
    first_blk = 1'b1;
  endfunction

  function automatic pulse_t rand_pulse();
    pulse_t p;
    p.dcc = 9'($urandom);  p.dcl = 8'($urandom_range(0, 9));
    p.dca = 8'($urandom);  p.dcs = 8'($urandom_range(0, 8));
    p.acc = 16'($urandom); p.acl = 8'($urandom_range(0, 16));
    p.aca = 8'($urandom);  p.acs = 8'($urandom_range(0, 8));
    p.last = ($urandom_range(0, 3) == 0);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    reset_n = 1'b0; jpeg_out_enable = 1'b0; flush = 1'b0; byte_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
  endtask

  task automatic set_fields(input pulse_t p);
    jpeg_dc_out = p.dcc; jpeg_dc_out_length = p.dcl;
    jpeg_dc_code_list = p.dca; jpeg_dc_code_size = p.dcs;
    huffman_code = p.acc; huffman_code_length = p.acl;
    code_out = p.aca; code_size_out = p.acs; jpeg_out_end = p.last;
  endtask

  task automatic drive_pulse(input pulse_t p, input int gap, input bit rand_ready);
    @(posedge clock); #1;
    set_fields(p);
    jpeg_out_enable = 1'b1;
    @(posedge clock); #1;
    jpeg_out_enable = 1'b0;
    set_fields(rand_pulse());
    repeat (gap) begin
      @(posedge clock); #1;
      if (rand_ready) byte_ready = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic do_flush(output bit timed_out);
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (flush_done) begin timed_out = 1'b0; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clock);
    total++; if (byte_valid !== 1'b0)  begin bad++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
    total++; if (byte_out !== 8'h00)   begin bad++; $display("FAIL reset_byte_out got=%h exp=00", byte_out); end
    total++; if (packer_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", packer_busy); end
    total++; if (flush_done !== 1'b0)  begin bad++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
  endtask

  task automatic test_minimal(input string tag);
    pulse_t p;
    bit to;
    p = '{dcc: 9'h000, dcl: 8'd2, dca: 8'h00, dcs: 8'd0,
          acc: 16'h000A, acl: 8'd4, aca: 8'h00, acs: 8'd0, last: 1'b1};
    model_pulse(p);
    drive_pulse(p, 6, 1'b0);
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL %s_flush_done got=timeout exp=pulse", tag); end
    @(negedge clock);
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b exp=0", tag, flush_done); end
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h2B) begin
      bad++; $display("FAIL %s_byte got_n=%0d got0=%h exp=2B", tag, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size()); end
    total++; if (packer_busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", tag, packer_busy); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stuffing();
    pulse_t p;
    bit to;
    p = '{dcc: 9'h1FF, dcl: 8'd9, dca: 8'h00, dcs: 8'd0,
          acc: 16'h007F, acl: 8'd7, aca: 8'h00, acs: 8'd0, last: 1'b1};
    model_pulse(p);
    drive_pulse(p, 6, 1'b0);
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL stuff_flush_done got=timeout exp=pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stuff_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stuff_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_empty_flush();
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL empty_flush_done got=%b exp=1", flush_done); end
    @(negedge clock);
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL empty_flush_width got=%b exp=0", flush_done); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_flush_bytes got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    pulse_t p;
    bit to, seen;
    logic [7:0] hold;
    p = '{dcc: 9'h0A5, dcl: 8'd9, dca: 8'h3C, dcs: 8'd8,
          acc: 16'h1234, acl: 8'd13, aca: 8'h00, acs: 8'd0, last: 1'b1};
    byte_ready = 1'b0;
    model_pulse(p);
    drive_pulse(p, 2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = byte_valid;
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_valid got=0 exp=1"); end
    hold = byte_out;
    total++; if (hold !== exp_q[0]) begin bad++; $display("FAIL bp_first got=%h exp=%h", hold, exp_q[0]); end
    repeat (5) begin
      @(negedge clock);
      total++; if (byte_valid !== 1'b1 || byte_out !== hold) begin
        bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", byte_valid, byte_out, hold);
      end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_no_xfer got=%0d exp=0", got_q.size()); end
    @(posedge clock); #1 byte_ready = 1'b1;
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL bp_flush_done got=timeout exp=pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_block_boundary();
    pulse_t p [3];
    bit to;
    p[0] = '{dcc: 9'h0F0, dcl: 8'd9, dca: 8'h05, dcs: 8'd3,
             acc: 16'h0003, acl: 8'd2, aca: 8'h01, acs: 8'd1, last: 1'b0};
    p[1] = '{dcc: 9'h1FF, dcl: 8'd9, dca: 8'hFF, dcs: 8'd8,
             acc: 16'h0015, acl: 8'd5, aca: 8'h02, acs: 8'd2, last: 1'b1};
    p[2] = '{dcc: 9'h1A5, dcl: 8'd9, dca: 8'h00, dcs: 8'd0,
             acc: 16'h000A, acl: 8'd4, aca: 8'h06, acs: 8'd3, last: 1'b1};
    for (int i = 0; i < 3; i++) begin
      model_pulse(p[i]);
      drive_pulse(p[i], 8, 1'b0);
    end
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL blk_flush_done got=timeout exp=pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL blk_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL blk_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    pulse_t p;
    bit to;
    repeat (30) begin
      p = rand_pulse();
      model_pulse(p);
      drive_pulse(p, 11, 1'b1);
    end
    byte_ready = 1'b1;
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL rnd_flush_done got=timeout exp=pulse"); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rnd_overflow got=%b exp=0", overflow); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_clamp();
    pulse_t p;
    bit to;
    reset_dut();
    p = '{dcc: 9'h055, dcl: 8'd7, dca: 8'h0B, dcs: 8'd4,
          acc: 16'hBEEF, acl: 8'd20, aca: 8'h02, acs: 8'd2, last: 1'b1};
    model_pulse(p);
    drive_pulse(p, 6, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clamp_overflow got=%b exp=1", overflow); end
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL clamp_flush_done got=timeout exp=pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL clamp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL clamp_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    pulse_t p, q;
    bit to;
    reset_dut();
    p = '{dcc: 9'h123, dcl: 8'd9, dca: 8'h81, dcs: 8'd8,
          acc: 16'h5A5A, acl: 8'd16, aca: 8'h7E, acs: 8'd8, last: 1'b1};
    byte_ready = 1'b0;
    drive_pulse(p, 7, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL acc_ovf_first got=%b exp=0", overflow); end
    drive_pulse(p, 7, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL acc_ovf_second got=%b exp=1", overflow); end
    repeat (10) @(negedge clock);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL acc_ovf_sticky got=%b exp=1", overflow); end
    // Second pulse arrives two cycles after the first, while the FSM is busy.
    reset_dut();
    q = '{dcc: 9'h1C3, dcl: 8'd9, dca: 8'h3F, dcs: 8'd6,
          acc: 16'h00F0, acl: 8'd8, aca: 8'h11, acs: 8'd5, last: 1'b0};
    model_pulse(p);
    @(posedge clock); #1 set_fields(p); jpeg_out_enable = 1'b1;
    @(posedge clock); #1 jpeg_out_enable = 1'b0;
    @(posedge clock); #1 set_fields(q); jpeg_out_enable = 1'b1;
    @(posedge clock); #1 jpeg_out_enable = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL collide_overflow got=%b exp=1", overflow); end
    model_flush();
    do_flush(to);
    total++; if (to) begin bad++; $display("FAIL collide_flush_done got=timeout exp=pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL collide_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL collide_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    pulse_t p;
    bit seen;
    reset_dut();
    p = '{dcc: 9'h1FF, dcl: 8'd9, dca: 8'h00, dcs: 8'd0,
          acc: 16'h007F, acl: 8'd7, aca: 8'h00, acs: 8'd0, last: 1'b1};
    byte_ready = 1'b0;
    drive_pulse(p, 3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = byte_valid;
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_valid got=0 exp=1"); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (byte_valid !== 1'b0 || byte_out !== 8'h00) begin
      bad++; $display("FAIL mid_reset_byte got=%b/%h exp=0/00", byte_valid, byte_out);
    end
    total++; if (packer_busy !== 1'b0 || overflow !== 1'b0 || flush_done !== 1'b0) begin
      bad++; $display("FAIL mid_reset_flags got=%b%b%b exp=000", packer_busy, overflow, flush_done);
    end
    model_clear();
    byte_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    test_minimal("after_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_minimal("minimal");
    test_empty_flush();
    test_stuffing();
    test_backpressure();
    test_block_boundary();
    test_random();
    test_clamp();
    test_errors();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
